// File: rtl/char_motion.sv
// Per-frame character physics (walk, jump, gravity, landing) and HP/invulnerability tracking.
// Optional build macro CHAR_DOUBLE_JUMP_EN enables one extra airborne jump per flight.
module char_motion #(
    parameter int SCREEN_W      = 1024,
    parameter int CHAR_W        = 32,
    parameter int CHAR_H        = 48,
    parameter int X_INIT        = 100,
    parameter int Y_INIT        = 100,
    parameter int STEP_X        = 4,
    parameter int JUMP_V        = 12,
    parameter int GRAVITY       = 1,
    parameter int VMAX_FALL     = 12,
    parameter int HP_W          = 4,
    parameter int HP_MAX        = 10,
    parameter int INVULN_FRAMES = 60
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick,
    input  logic            stepleft,
    input  logic            stepright,
    input  logic            stepjump,
    input  logic [11:0]     ground_y,
    input  logic            hit,
    input  logic [HP_W-1:0] hit_dmg,
    output logic [11:0]     pos_x,
    output logic [11:0]     pos_y,
    output logic            flip_h,
    output logic [HP_W-1:0] char_hp,
    output logic            on_ground,
    output logic [2:0]      state,
    output logic            alive
);

    typedef enum logic [2:0] {IDLE = 3'd0, WALK = 3'd1, AIR = 3'd2, HURT = 3'd3, DEAD = 3'd4} state_t;

    localparam int INV_W = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
    localparam logic [INV_W-1:0]  INV_LOAD = INV_W'(INVULN_FRAMES);
    localparam logic signed [13:0] X_MAX   = 14'(SCREEN_W - CHAR_W);
    localparam logic signed [13:0] Y_MAX   = 14'(4095);
    localparam logic signed [13:0] STEP    = 14'(STEP_X);
    localparam logic signed [13:0] H       = 14'(CHAR_H);
    localparam logic signed [7:0]  VJ      = 8'(-JUMP_V);
    localparam logic signed [8:0]  G9      = 9'(GRAVITY);
    localparam logic signed [8:0]  VMAX9   = 9'(VMAX_FALL);

    function automatic logic [11:0] clamp_pos(input logic signed [13:0] v, input logic signed [13:0] hi);
        if (v[13])       return 12'd0;
        else if (v > hi) return hi[11:0];
        else             return v[11:0];
    endfunction

    function automatic logic signed [7:0] sat_fall(input logic signed [7:0] v);
        logic signed [8:0] s;
        s = $signed({v[7], v}) + G9;
        return (s > VMAX9) ? VMAX9[7:0] : s[7:0];
    endfunction

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
        return (b >= a) ? '0 : (a - b);
    endfunction

    state_t             st, st_n;
    logic signed [7:0]  vy, vy_n, vy_t;
    logic [INV_W-1:0]   inv, inv_n;
    logic [11:0]        x_n, y_n;
    logic [HP_W-1:0]    hp_n;
    logic               flip_n, og_n, hit_ok, dead_n, jump, fall;
    logic signed [13:0] xs, ys, gy, y_t;
`ifdef CHAR_DOUBLE_JUMP_EN
    logic               dj_armed, dj_armed_n, jump_rel, jump_rel_n;
`endif

    assign xs    = $signed({2'b00, pos_x});
    assign ys    = $signed({2'b00, pos_y});
    assign gy    = $signed({2'b00, ground_y});
    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x     <= 12'(X_INIT);
            pos_y     <= 12'(Y_INIT);
            vy        <= '0;
            flip_h    <= 1'b0;
            char_hp   <= HP_W'(HP_MAX);
            on_ground <= 1'b0;
            st        <= AIR;
            alive     <= 1'b1;
            inv       <= '0;
`ifdef CHAR_DOUBLE_JUMP_EN
            dj_armed  <= 1'b1;
            jump_rel  <= 1'b1;
`endif
        end else begin
            pos_x     <= x_n;
            pos_y     <= y_n;
            vy        <= vy_n;
            flip_h    <= flip_n;
            char_hp   <= hp_n;
            on_ground <= og_n;
            st        <= st_n;
            alive     <= !dead_n;
            inv       <= inv_n;
`ifdef CHAR_DOUBLE_JUMP_EN
            dj_armed  <= dj_armed_n;
            jump_rel  <= jump_rel_n;
`endif
        end
    end

    always_comb begin
        x_n    = pos_x;
        y_n    = pos_y;
        vy_n   = vy;
        vy_t   = vy;
        y_t    = '0;
        flip_n = flip_h;
        og_n   = on_ground;
        hp_n   = char_hp;
        inv_n  = inv;
        st_n   = st;
        jump   = 1'b0;
        fall   = 1'b0;
`ifdef CHAR_DOUBLE_JUMP_EN
        dj_armed_n = dj_armed;
        jump_rel_n = jump_rel;
`endif
        // A hit landing on a tick reloads the counter; the tick decrement is lost that frame.
        hit_ok = hit && (inv == '0) && (st != DEAD);
        if (hit_ok) begin
            hp_n  = sat_sub(char_hp, hit_dmg);
            inv_n = INV_LOAD;
        end else if (frame_tick && (inv != '0)) begin
            inv_n = inv - INV_W'(1);
        end
        dead_n = (st == DEAD) || (hp_n == '0);

        if (frame_tick && !dead_n) begin
            if (stepleft && !stepright) begin
                x_n    = clamp_pos(xs - STEP, X_MAX);
                flip_n = 1'b1;
            end else if (stepright && !stepleft) begin
                x_n    = clamp_pos(xs + STEP, X_MAX);
                flip_n = 1'b0;
            end

            if (on_ground) begin
                if (stepjump)          jump = 1'b1;
                else if (gy > ys + H)  og_n = 1'b0;
            end else begin
`ifdef CHAR_DOUBLE_JUMP_EN
                if (stepjump && dj_armed && jump_rel) begin
                    jump       = 1'b1;
                    dj_armed_n = 1'b0;
                end else begin
                    fall = 1'b1;
                end
`else
                fall = 1'b1;
`endif
            end
`ifdef CHAR_DOUBLE_JUMP_EN
            if (!stepjump) jump_rel_n = 1'b1;
            if (jump)      jump_rel_n = 1'b0;
`endif

            if (jump)      vy_t = VJ;
            else if (fall) vy_t = sat_fall(vy);

            // Ceiling clamp kills upward speed; landing snaps feet onto the ground.
            if (jump || fall) begin
                y_t  = ys + $signed({{6{vy_t[7]}}, vy_t});
                y_n  = clamp_pos(y_t, Y_MAX);
                vy_n = y_t[13] ? '0 : vy_t;
                og_n = 1'b0;
                if (!on_ground && (y_t + H >= gy)) begin
                    y_n  = clamp_pos(gy - H, Y_MAX);
                    vy_n = '0;
                    og_n = 1'b1;
`ifdef CHAR_DOUBLE_JUMP_EN
                    dj_armed_n = 1'b1;
`endif
                end
            end
        end

        if (frame_tick || hit_ok) begin
            if (dead_n)                    st_n = DEAD;
            else if (inv_n != '0)          st_n = HURT;
            else if (!og_n)                st_n = AIR;
            else if (stepleft ^ stepright) st_n = WALK;
            else                           st_n = IDLE;
        end
    end

endmodule

// File: tb/tb_char_motion.sv
// Scoreboarded bench for char_motion: table-driven walk vectors plus jump, ledge, damage and reset sequences.
module tb_char_motion;

    logic        clk = 1'b0, rst = 1'b1, frame_tick = 1'b0;
    logic        stepleft = 1'b0, stepright = 1'b0, stepjump = 1'b0, hit = 1'b0;
    logic [11:0] ground_y = 12'd400;
    logic [3:0]  hit_dmg = 4'd0;
    logic [11:0] pos_x, pos_y;
    logic        flip_h, on_ground, alive;
    logic [3:0]  char_hp;
    logic [2:0]  state;

    always #5 clk = ~clk;

    char_motion dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump),
        .ground_y(ground_y), .hit(hit), .hit_dmg(hit_dmg),
        .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h), .char_hp(char_hp),
        .on_ground(on_ground), .state(state), .alive(alive)
    );

    localparam int S_IDLE = 0, S_WALK = 1, S_AIR = 2, S_HURT = 3, S_DEAD = 4;

    int passed = 0, total = 0;
    int e_x = 100, e_y = 100, e_flip = 0, e_hp = 10, e_og = 0, e_st = S_AIR, e_alive = 1;
    int n;

    typedef struct {
        string nm;
        int x, y, flip, hp, og, st, alive;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit l, r;
        int x, flip, st;
    } vec_t;
    vec_t tbl[5];

    task automatic cmp(input string nm, input int act, input int want);
        total++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    endtask

    task automatic sb_push(input string nm);
        exp_t e;
        e.nm = nm; e.x = e_x; e.y = e_y; e.flip = e_flip; e.hp = e_hp;
        e.og = e_og; e.st = e_st; e.alive = e_alive;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_underflow", 0, 1);
            return;
        end
        e = sb.pop_front();
        cmp({e.nm, ".pos_x"},     int'(pos_x),     e.x);
        cmp({e.nm, ".pos_y"},     int'(pos_y),     e.y);
        cmp({e.nm, ".flip_h"},    int'(flip_h),    e.flip);
        cmp({e.nm, ".char_hp"},   int'(char_hp),   e.hp);
        cmp({e.nm, ".on_ground"}, int'(on_ground), e.og);
        cmp({e.nm, ".state"},     int'(state),     e.st);
        cmp({e.nm, ".alive"},     int'(alive),     e.alive);
    endtask

    task automatic drive(input bit l, input bit r, input bit j, input bit tk, input bit h, input int dmg);
        @(negedge clk);
        stepleft = l; stepright = r; stepjump = j;
        frame_tick = tk; hit = h; hit_dmg = 4'(dmg);
        @(posedge clk);
        #1;
        frame_tick = 1'b0; hit = 1'b0;
    endtask

    task automatic tick(input bit l, input bit r, input bit j);
        drive(l, r, j, 1'b1, 1'b0, 0);
    endtask

    task automatic chk_tick(input string nm, input bit l, input bit r, input bit j);
        sb_push(nm);
        tick(l, r, j);
        sb_check();
    endtask

    task automatic land_loop(input bit j, input int bound);
        n = 0;
        while (!on_ground && n < bound) begin
            tick(1'b0, 1'b0, j);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{l: 1'b0, r: 1'b1, x: 104, flip: 0, st: S_WALK};
        tbl[1] = '{l: 1'b1, r: 1'b0, x: 100, flip: 1, st: S_WALK};
        tbl[2] = '{l: 1'b1, r: 1'b1, x: 100, flip: 1, st: S_IDLE};
        tbl[3] = '{l: 1'b0, r: 1'b0, x: 100, flip: 1, st: S_IDLE};
        tbl[4] = '{l: 1'b0, r: 1'b1, x: 104, flip: 0, st: S_WALK};

        #13;
        sb_push("reset");
        #1;
        sb_check();
        @(negedge clk);
        rst = 1'b0;

        // Free fall from y=100 onto ground 400: y = 100 + n(n+1)/2, clamped speed 12 after 12 ticks.
        e_y = 101; chk_tick("fall1", 0, 0, 0);
        e_y = 103; chk_tick("fall2", 0, 0, 0);
        e_y = 106; chk_tick("fall3", 0, 0, 0);
        land_loop(1'b0, 60);
        cmp("fall_land_ticks", n + 3, 27);
        e_y = 352; e_og = 1; e_st = S_IDLE;
        chk_tick("rest", 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            e_x = tbl[i].x; e_flip = tbl[i].flip; e_st = tbl[i].st;
            chk_tick($sformatf("walk_vec%0d", i), tbl[i].l, tbl[i].r, 1'b0);
        end

        repeat (249) tick(0, 1, 0);
        e_x = 992; e_flip = 0; e_st = S_WALK;
        chk_tick("sat_right", 0, 1, 0);
        e_st = S_IDLE;
        chk_tick("both_hold", 1, 1, 0);
        repeat (259) tick(1, 0, 0);
        e_x = 0; e_flip = 1; e_st = S_WALK;
        chk_tick("sat_left", 1, 0, 0);

        e_y = 340; e_og = 0; e_st = S_AIR;
        chk_tick("jump", 0, 0, 1);
`ifdef CHAR_DOUBLE_JUMP_EN
        e_y = 329; chk_tick("dj_release", 0, 0, 0);
        e_y = 317; chk_tick("dj_second", 0, 0, 1);
        e_y = 306; chk_tick("dj_release2", 0, 0, 0);
        e_y = 296; chk_tick("dj_third_ignored", 0, 0, 1);
        land_loop(1'b0, 60);
        cmp("dj_land_y", int'(pos_y), 352);
        cmp("dj_land_og", int'(on_ground), 1);
`else
        repeat (10) tick(0, 0, 0);
        e_y = 274; chk_tick("apex", 0, 0, 0);
        e_y = 274; chk_tick("apex_hold", 0, 0, 0);
        land_loop(1'b1, 40);
        cmp("jump_land_ticks", n, 12);
        cmp("jump_land_y", int'(pos_y), 352);
        cmp("jump_land_state", int'(state), S_IDLE);
        e_y = 340; e_og = 0; e_st = S_AIR;
        chk_tick("rejump_held", 0, 0, 1);
        land_loop(1'b0, 40);
        cmp("rejump_land_y", int'(pos_y), 352);
`endif
        e_y = 352; e_og = 1; e_st = S_IDLE;
        chk_tick("settled", 0, 0, 0);

        ground_y = 12'd500;
        e_og = 0; e_st = S_AIR;
        chk_tick("ledge", 0, 0, 0);
        e_y = 353;
        chk_tick("ledge_fall", 0, 0, 0);
        land_loop(1'b0, 40);
        cmp("ledge_land_y", int'(pos_y), 452);
        e_y = 452; e_og = 1; e_st = S_IDLE;

        e_hp = 7; e_st = S_HURT;
        sb_push("hit1");
        drive(0, 0, 0, 0, 1, 3);
        sb_check();
        e_x = 4; e_flip = 0;
        chk_tick("hurt_move", 0, 1, 0);
        repeat (9) tick(0, 0, 0);
        sb_push("hit_ignored");
        drive(0, 0, 0, 0, 1, 3);
        sb_check();
        repeat (48) tick(0, 0, 0);
        chk_tick("hurt_tick59", 0, 0, 0);
        e_st = S_IDLE;
        chk_tick("hurt_recover", 0, 0, 0);

        e_hp = 5; e_st = S_HURT;
        sb_push("hit_on_tick");
        drive(0, 0, 0, 1, 1, 2);
        sb_check();
        repeat (58) tick(0, 0, 0);
        chk_tick("hit_on_tick_59", 0, 0, 0);
        e_st = S_IDLE;
        chk_tick("hit_on_tick_60", 0, 0, 0);

        e_hp = 0; e_st = S_DEAD; e_alive = 0;
        sb_push("kill_sat");
        drive(0, 0, 0, 0, 1, 15);
        sb_check();
        chk_tick("dead_frozen1", 1, 0, 1);
        chk_tick("dead_frozen2", 0, 1, 0);
        sb_push("dead_hit");
        drive(0, 0, 0, 0, 1, 1);
        sb_check();

        @(negedge clk);
        stepleft = 1'b0; stepright = 1'b0; stepjump = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        e_x = 100; e_y = 100; e_flip = 0; e_hp = 10; e_og = 0; e_st = S_AIR; e_alive = 1;
        sb_push("async_reset");
        sb_check();
        @(negedge clk);
        rst = 1'b0;
        e_y = 101;
        chk_tick("post_reset_fall", 0, 0, 0);

        cmp("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
